// File: rtl/hdmi_frame_scheduler.sv
// hdmi_frame_scheduler: frame-granular round-robin sharing of the HDMI
// pixel sink among NSRC sources, with background fill on idle/underrun.
module hdmi_frame_scheduler #(
    parameter int unsigned NSRC     = 4,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic               clk_st,
    input  logic               reset_n,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic [10:0]        horz,
    input  logic [10:0]        vert,
    input  logic               sink_ready,
    output logic               sink_valid,
    output logic [23:0]        sink_data,
    input  logic [NSRC-1:0]    src_req,
    input  logic [NSRC-1:0]    src_valid,
    input  logic [24*NSRC-1:0] src_data,
    output logic [NSRC-1:0]    src_ready,
    output logic               gnt_valid,
    output logic [2:0]         gnt_idx,
    output logic               frame_done,
    output logic [15:0]        underrun_cnt
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]  state;
    logic [2:0]  ptr;
    logic        active;
    logic        last;
    logic [7:0]  req8;
    logic [7:0]  valid8;
    logic [23:0] pix [8];
    logic [2:0]  base;
    logic [2:0]  next_idx;
    logic        next_found;
    logic [3:0]  sum;

    assign active = (x < horz) && (y < vert) && sink_ready;
    assign last   = active && (x == horz - 11'd1) && (y == vert - 11'd1);

    assign gnt_valid = (state == S_STREAM);
    assign req8      = 8'(src_req);
    assign valid8    = 8'(src_valid);

    // Pad the source pixels to eight slots so the owner index selects directly.
    for (genvar g = 0; g < 8; g++) begin : g_pix
        if (g < NSRC) begin : g_real
            assign pix[g] = src_data[24*g +: 24];
        end else begin : g_pad
            assign pix[g] = '0;
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_rdy
        assign src_ready[g] = active && gnt_valid && (gnt_idx == 3'(g));
    end

    assign base = gnt_valid ? gnt_idx : ptr;

    // Nearest requester after base; base itself is tried last.
    always_comb begin
        next_idx   = base;
        next_found = 1'b0;
        sum        = '0;
        for (int k = NSRC; k >= 1; k--) begin
            sum = {1'b0, base} + 4'(k);
            if (sum >= 4'(NSRC)) sum = sum - 4'(NSRC);
            if (req8[sum[2:0]]) begin
                next_idx   = sum[2:0];
                next_found = 1'b1;
            end
        end
    end

    // Pixel path: forward the owner's pixel or fill with background.
    always_ff @(posedge clk_st) begin
        if (!reset_n) begin
            sink_valid   <= 1'b0;
            sink_data    <= 24'h0;
            frame_done   <= 1'b0;
            underrun_cnt <= 16'h0;
        end else begin
            sink_valid <= active;
            frame_done <= last;
            if (active) begin
                if (gnt_valid && valid8[gnt_idx]) begin
                    sink_data <= pix[gnt_idx];
                end else begin
                    sink_data <= BG_COLOR;
                    if (gnt_valid && underrun_cnt != 16'hFFFF)
                        underrun_cnt <= underrun_cnt + 16'd1;
                end
            end
        end
    end

    // Ownership changes only on the last active pixel of a frame.
    always_ff @(posedge clk_st) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            gnt_idx <= 3'd0;
            ptr     <= 3'(NSRC - 1);
        end else if (last) begin
            if (next_found) begin
                state   <= S_STREAM;
                gnt_idx <= next_idx;
                ptr     <= next_idx;
            end else begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_scheduler.sv
// tb_hdmi_frame_scheduler: randomized raster/source stimulus against a
// frame-level reference model, checked through a scoreboard monitor.
module tb_hdmi_frame_scheduler;

    localparam int NSRC = 4;
    localparam logic [23:0] BG = 24'h000000;

    logic               clk_st = 1'b0;
    logic               reset_n = 1'b0;
    logic [10:0]        x = '0, y = '0, horz = '0, vert = '0;
    logic               sink_ready = 1'b0;
    logic               sink_valid;
    logic [23:0]        sink_data;
    logic [NSRC-1:0]    src_req = '0;
    logic [NSRC-1:0]    src_valid = '0;
    logic [24*NSRC-1:0] src_data = '0;
    logic [NSRC-1:0]    src_ready;
    logic               gnt_valid;
    logic [2:0]         gnt_idx;
    logic               frame_done;
    logic [15:0]        underrun_cnt;

    hdmi_frame_scheduler #(.NSRC(NSRC), .BG_COLOR(BG)) dut (
        .clk_st(clk_st), .reset_n(reset_n),
        .x(x), .y(y), .horz(horz), .vert(vert),
        .sink_ready(sink_ready), .sink_valid(sink_valid),
        .sink_data(sink_data), .src_req(src_req),
        .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx), .frame_done(frame_done),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk_st = ~clk_st;

    typedef struct packed {
        logic        v;
        logic        d;
        logic        gv;
        logic [2:0]  gi;
        logic [15:0] uc;
    } st_t;

    st_t         st_q[$];
    logic [23:0] beat_q[$];
    int checks = 0;
    int failures = 0;

    int          owner = -1;
    int          mptr = NSRC - 1;
    logic [15:0] muc = '0;
    int          cnt[NSRC];

    function automatic logic [23:0] pat(int i, int k);
        return {4'(i + 1), 20'(k)};
    endfunction

    function automatic logic [NSRC-1:0] vfn(int mode, int p, logic [63:0] m);
        case (mode)
            0: return '1;
            1: return NSRC'($urandom);
            2: return m[p] ? '0 : '1;
            default: return '0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus plus the model's view of that clock.
    task automatic cyc(input bit rst, input int xi, input int yi,
                       input int h, input int v, input bit sr,
                       input logic [NSRC-1:0] req,
                       input logic [NSRC-1:0] vld);
        bit act, lst, found;
        int base, idx;
        logic [NSRC-1:0] exp_rdy;
        st_t s;
        @(negedge clk_st);
        reset_n = rst;
        x = 11'(xi); y = 11'(yi);
        horz = 11'(h); vert = 11'(v);
        sink_ready = sr; src_req = req; src_valid = vld;
        for (int i = 0; i < NSRC; i++) src_data[24*i +: 24] = pat(i, cnt[i]);
        #1;
        act = (xi < h) && (yi < v) && sr;
        lst = act && (xi == h - 1) && (yi == v - 1);
        exp_rdy = (act && owner >= 0) ? NSRC'(1 << owner) : '0;
        chk("src_ready", 32'(src_ready), 32'(exp_rdy));
        if (act && owner >= 0 && vld[owner]) begin
            if (rst) beat_q.push_back(pat(owner, cnt[owner]));
            cnt[owner]++;
        end else if (act && rst) begin
            beat_q.push_back(BG);
            if (owner >= 0 && muc != 16'hFFFF) muc++;
        end
        if (!rst) begin
            owner = -1; mptr = NSRC - 1; muc = '0;
        end else if (lst) begin
            base = (owner >= 0) ? owner : mptr;
            found = 0;
            for (int k = 1; k <= NSRC; k++) begin
                idx = (base + k) % NSRC;
                if (!found && req[idx]) begin
                    found = 1; owner = idx; mptr = idx;
                end
            end
            if (!found) owner = -1;
        end
        s.v  = rst && act;
        s.d  = rst && lst;
        s.gv = owner >= 0;
        s.gi = (owner >= 0) ? 3'(owner) : 3'd0;
        s.uc = muc;
        st_q.push_back(s);
    endtask

    task automatic frame(input int h, input int v,
                         input logic [NSRC-1:0] req,
                         input logic [NSRC-1:0] req2,
                         input int drop_at, input int vmode,
                         input logic [63:0] mask,
                         input int rdy_pct, input int rst_at);
        int p = 0;
        bit r = 1;
        logic [NSRC-1:0] rq = req;
        for (int yy = 0; yy < v; yy++) begin
            for (int xx = 0; xx < h; xx++) begin
                rq = (drop_at >= 0 && p >= drop_at) ? req2 : req;
                if (rst_at >= 0 && p >= rst_at) r = 0;
                while (rdy_pct < 100 && $urandom_range(99) >= rdy_pct)
                    cyc(r, xx, yy, h, v, 0, rq, vfn(vmode, p, mask));
                cyc(r, xx, yy, h, v, 1, rq, vfn(vmode, p, mask));
                p++;
            end
        end
        for (int b = 0; b < 3; b++) cyc(1, h, 0, h, v, 1, rq, '1);
    endtask

    task automatic chk_gnt(string nm, int idx);
        chk({nm, "_gv"}, 32'(gnt_valid), 32'd1);
        chk({nm, "_gi"}, 32'(gnt_idx), 32'(idx));
    endtask

    // Monitor: compare every registered cycle against the scoreboard.
    initial begin
        st_t s;
        logic [23:0] b;
        forever begin
            @(posedge clk_st);
            #1;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("sink_valid", 32'(sink_valid), 32'(s.v));
                chk("frame_done", 32'(frame_done), 32'(s.d));
                chk("gnt_valid", 32'(gnt_valid), 32'(s.gv));
                if (s.gv) chk("gnt_idx", 32'(gnt_idx), 32'(s.gi));
                chk("underrun_cnt", 32'(underrun_cnt), 32'(s.uc));
                if (sink_valid) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_unexpected", 32'(sink_data), 32'hFFFF_FFFF);
                    end else begin
                        b = beat_q.pop_front();
                        chk("sink_data", 32'(sink_data), 32'(b));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NSRC; i++) cnt[i] = 0;
        cyc(0, 0, 0, 0, 0, 0, '0, '0);
        cyc(0, 0, 0, 0, 0, 0, '0, '0);
        cyc(1, 0, 0, 0, 0, 0, '0, '0);
        chk("rst_sink_data", 32'(sink_data), 32'h0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_underrun", 32'(underrun_cnt), 32'h0);

        frame(4, 2, 4'b0000, 4'b0000, -1, 0, '0, 100, -1);
        chk("f1_idle", 32'(gnt_valid), 32'd0);
        frame(4, 2, 4'b0101, 4'b0000, -1, 0, '0, 100, -1);
        chk_gnt("f2", 0);
        frame(4, 2, 4'b0101, 4'b0000, -1, 0, '0, 100, -1);
        chk_gnt("f3", 2);
        frame(4, 2, 4'b0101, 4'b0000, -1, 0, '0, 100, -1);
        chk_gnt("f4", 0);
        frame(4, 2, 4'b0010, 4'b0000, -1, 0, '0, 100, -1);
        chk_gnt("f5", 1);
        chk("f5_underrun", 32'(underrun_cnt), 32'd0);
        frame(4, 2, 4'b0010, 4'b1000, 1, 2, 64'h25, 100, -1);
        chk("f6_underrun", 32'(underrun_cnt), 32'd3);
        chk_gnt("f6", 3);

        for (int f = 0; f < 30; f++) begin
            int h, v;
            h = $urandom_range(1, 6);
            v = $urandom_range(1, 4);
            frame(h, v, NSRC'($urandom), NSRC'($urandom),
                  int'($urandom_range(0, h * v)), 1, '0, 70, -1);
        end

        frame(4, 2, 4'b1111, 4'b1111, -1, 0, '0, 100, 6);
        chk("rst_mid_gv", 32'(gnt_valid), 32'd0);
        chk("rst_mid_uc", 32'(underrun_cnt), 32'd0);
        frame(4, 2, 4'b1111, 4'b0000, -1, 0, '0, 100, -1);
        chk_gnt("post_rst", 0);
        frame(4, 2, 4'b0001, 4'b0000, -1, 0, '0, 100, -1);
        chk_gnt("pre_sat", 0);

        @(posedge clk_st);
        #2;
        force dut.underrun_cnt = 16'hFFFE;
        @(negedge clk_st);
        release dut.underrun_cnt;
        muc = 16'hFFFE;
        frame(4, 2, 4'b0001, 4'b0000, -1, 3, '0, 100, -1);
        chk("sat_underrun", 32'(underrun_cnt), 32'hFFFF);

        for (int yy = 0; yy < 2; yy++)
            for (int xx = 0; xx < 4; xx++)
                cyc(1, xx, yy, 0, 2, 1, 4'b1111, 4'b1111);
        cyc(1, 0, 0, 0, 2, 1, 4'b1111, 4'b1111);
        chk("h0_valid", 32'(sink_valid), 32'd0);
        chk("h0_done", 32'(frame_done), 32'd0);

        @(posedge clk_st);
        #3;
        chk("st_q_drain", 32'(st_q.size()), 32'd0);
        chk("beat_q_drain", 32'(beat_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
